shared_reg_arb: RTL and testbench
=================================

Name: shared_reg_arb

Overview:
Round-robin arbiter and write controller for one shared W-bit enabled register. N_REQ requesters compete for exclusive write ownership through a req/gnt handshake. Only the current owner's write data reaches the register, and each ownership is bounded by a timeout so no requester can starve the others. The block sits between requester-side control logic and the shared state register. It owns that register and presents its value to all consumers.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, shared register width
RST_VAL, 4'b0001, register value after reset (W bits)
MAX_HOLD, 4, maximum consecutive granted cycles per ownership (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester ownership request, level, held while ownership is wanted
wr_en  input  N_REQ  per-requester write strobe; honoured only for the current owner
wr_data  input  N_REQ*W  packed write data; requester i uses bits [i*W +: W]
gnt  output  N_REQ  registered one-hot grant (all zero when idle)
owner  output  $clog2(N_REQ)  index of current owner; valid only while busy=1
busy  output  1  1 while any grant is active
q  output  W  shared register value

Behaviour:
Reset (rst=1 at a rising edge):
- Results: q=RST_VAL, gnt=0, busy=0, owner=0, state=IDLE, hold_cnt=0, rr pointer last=N_REQ-1.
- Requester 0 therefore has top priority after reset.
- rst overrides everything, including a write presented in the same cycle. That write is discarded.

States: IDLE, OWN.

IDLE:
- If req is nonzero, pick the first asserted index searching last+1, last+2, ... (mod N_REQ).
- At the next edge: gnt[pick]=1, owner=pick, busy=1, hold_cnt=1, last=pick, state=OWN.
- If req is zero, remain in IDLE.
- Grant latency is one cycle from req seen to gnt visible.

OWN:
- Write: on any edge with gnt[i]=1 and wr_en[i]=1, q takes wr_data[i]. This includes the last granted cycle and the cycle in which req[i] drops.
- Non-owner wr_en is ignored. No write ever occurs in IDLE.
- Release: if req[owner]=0 in a granted cycle, at the next edge gnt=0, busy=0, state=IDLE.
- Timeout: if hold_cnt==MAX_HOLD and req[owner] is still 1, forced release at the next edge, same as a normal release.
- Otherwise hold_cnt increments (saturating at MAX_HOLD is unnecessary, since release occurs there).
- After any release, the block spends exactly one cycle in IDLE with gnt=0 before the next grant. This bubble is mandatory, even if requests are pending.
- A timed-out requester that keeps req high is re-eligible, but rr order places it last.

General rules:
- gnt is always one-hot or zero. Never change gnt directly from one requester to another.
- q holds its value when no write occurs.
- Changes to req of non-owners during OWN have no effect until the next IDLE cycle.

Decomposition:
- Shared package: parameter defaults, state enum (IDLE, OWN), width helper for the owner index.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, last pointer.
  - Outputs: found flag, pick index.
- The FSM, hold counter, register and write mux stay in shared_reg_arb.

Test Plan:
- Reset check: assert rst 2 cycles, no req -> q=4'b0001, gnt=0000, busy=0. A write attempt with rst=1 (wr_en=0001, data 4'hF) leaves q=4'b0001.
- Single owner with write: req=0010 at cycle 0 -> gnt=0010 at cycle 1. wr_en[1]=1 with data 4'hA in cycle 1 -> q=4'hA at cycle 2. req drops in cycle 2 -> gnt=0000 at cycle 3.
- Round-robin fairness: req=1111 held continuously after reset, each owner holding for 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- Timeout: req=0001 held for 10 cycles, MAX_HOLD=4 -> gnt=0001 for exactly 4 cycles, 0 for 1 cycle, then 0001 again. With req=0101, the grant after timeout goes to 0100.
- Non-owner write ignored: owner 0 granted; wr_en=0100 with data 4'h7 -> q unchanged. Owner 0 writes 4'h3 in its final cycle -> q=4'h3.
- Reset mid-ownership: owner 2 granted and writing 4'h9 when rst=1 -> q=4'b0001, gnt=0 after the edge. First grant afterwards with req=0100|0001 goes to 0001.

Source files
------------

// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register arbiter: parameter defaults,
// controller state encoding and the owner-index width helper.
package shared_reg_arb_pkg;

    localparam int          N_REQ_DEF    = 4;
    localparam int          W_DEF        = 4;
    localparam int          MAX_HOLD_DEF = 4;
    localparam logic [3:0]  RST_VAL_DEF  = 4'b0001;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// the last-granted index, wrapping modulo N_REQ.
module shared_reg_arb_rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             found,
    output logic [IW-1:0]    pick
);

    int            cand;
    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        idx   = '0;
        // Scan last+1 .. last+N_REQ so the previous owner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            idx = IW'(cand);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin ownership arbiter and write controller for one shared register;
// each ownership is bounded by MAX_HOLD cycles and followed by one idle cycle.
module shared_reg_arb
    import shared_reg_arb_pkg::*;
#(
    parameter int           N_REQ    = N_REQ_DEF,
    parameter int           W        = W_DEF,
    parameter logic [W-1:0] RST_VAL  = W'(RST_VAL_DEF),
    parameter int           MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          wr_en,
    input  logic [N_REQ*W-1:0]        wr_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [idx_w(N_REQ)-1:0]   owner,
    output logic                      busy,
    output logic [W-1:0]              q
);

    localparam int IW = idx_w(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] last;
    logic          found;
    logic [IW-1:0] pick;
    logic          owner_wr;
    logic [W-1:0]  owner_data;
    logic          release_now;

    shared_reg_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req),
        .last  (last),
        .found (found),
        .pick  (pick)
    );

    // Only the current owner's strobe and lane can reach the register.
    assign owner_wr    = (state == OWN) && wr_en[owner];
    assign owner_data  = wr_data[owner*W +: W];
    assign release_now = !req[owner] || (hold_cnt == HW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= OWN;
                        gnt      <= N_REQ'(1) << pick;
                        owner    <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= HW'(1);
                        last     <= pick;
                    end
                end
                OWN: begin
                    // Release always passes through IDLE, giving the mandatory bubble.
                    if (release_now) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (owner_wr) begin
            q <= owner_data;
        end
    end

endmodule

// File: tb/tb_shared_reg_arb.sv
// Directed-vector bench for shared_reg_arb with hand-computed expectations.
module tb_shared_reg_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [15:0] wr_data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  q;

    int total;
    int bad;

    shared_reg_arb dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        req     = 4'b0000;
        wr_en   = 4'b0000;
        wr_data = 16'h0000;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        // Reset state, then a write attempt under reset.
        tick();
        tick();
        chk("rst_q", q, 4'b0001);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        wr_en   = 4'b0001;
        wr_data = 16'h000F;
        tick();
        chk("rst_wr_q", q, 4'b0001);
        rst     = 1'b0;
        wr_en   = 4'b0000;
        wr_data = 16'h0000;

        // Single owner with write.
        req = 4'b0010;
        tick();
        chk("single_gnt", gnt, 4'b0010);
        chk("single_busy", busy, 1'b1);
        chk("single_owner", owner, 2'd1);
        wr_en   = 4'b0010;
        wr_data = 16'h65A3;
        tick();
        chk("single_q", q, 4'hA);
        chk("single_gnt2", gnt, 4'b0010);
        req   = 4'b0000;
        wr_en = 4'b0000;
        tick();
        chk("single_rel_gnt", gnt, 4'b0000);
        chk("single_rel_busy", busy, 1'b0);
        chk("single_hold_q", q, 4'hA);

        // Round-robin with every requester pending.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), gnt, rr_exp[i]);
            tick();
            chk($sformatf("rr_hold%0d", i), gnt, rr_exp[i]);
            req = 4'b1111 & ~rr_exp[i];
            tick();
            chk($sformatf("rr_bubble%0d", i), gnt, 4'b0000);
            req = 4'b1111;
        end

        // Timeout with a single persistent requester.
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_gnt%0d", i), gnt, 4'b0001);
        end
        tick();
        chk("to_bubble", gnt, 4'b0000);
        tick();
        chk("to_regrant", gnt, 4'b0001);
        req = 4'b0101;
        tick();
        tick();
        tick();
        chk("to2_last_gnt", gnt, 4'b0001);
        tick();
        chk("to2_bubble", gnt, 4'b0000);
        tick();
        chk("to2_next_gnt", gnt, 4'b0100);
        chk("to2_owner", owner, 2'd2);
        req = 4'b0000;
        tick();
        chk("to2_rel", gnt, 4'b0000);

        // Non-owner write ignored, owner write in its final cycle, idle write ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0001;
        tick();
        chk("nw_gnt", gnt, 4'b0001);
        wr_en   = 4'b0100;
        wr_data = 16'h0700;
        tick();
        chk("nw_q", q, 4'b0001);
        wr_en = 4'b0000;
        tick();
        tick();
        chk("nw_final_gnt", gnt, 4'b0001);
        wr_en   = 4'b0001;
        wr_data = 16'hCBE3;
        tick();
        chk("nw_final_q", q, 4'h3);
        chk("nw_final_rel", gnt, 4'b0000);
        req     = 4'b0000;
        wr_en   = 4'b0001;
        wr_data = 16'h0005;
        tick();
        chk("idle_wr_q", q, 4'h3);
        wr_en = 4'b0000;

        // Reset in the middle of an ownership.
        req = 4'b0100;
        tick();
        chk("mid_gnt", gnt, 4'b0100);
        wr_en   = 4'b0100;
        wr_data = 16'h0900;
        rst     = 1'b1;
        tick();
        chk("mid_rst_q", q, 4'b0001);
        chk("mid_rst_gnt", gnt, 4'b0000);
        chk("mid_rst_busy", busy, 1'b0);
        rst   = 1'b0;
        wr_en = 4'b0000;
        req   = 4'b0101;
        tick();
        chk("mid_after_gnt", gnt, 4'b0001);
        chk("mid_after_owner", owner, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
